// File: rtl/sequence_checker.sv
// Memory-game sequence checker: grows a symbol sequence one round at a
// time, plays it back to the display, then scores the player's button entries.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   start               one-cycle pulse, begin a new game (IDLE/WIN/LOSE only)
//   rnd_en / rnd_in     request to / symbol from the generator (one cycle later)
//   btn_valid / btn_sym player entry pulse and its symbol
//   play_valid/play_sym symbol presentation to the display (registered)
//   round               current sequence length
//   busy / win / lose   game status flags
module sequence_checker #(
    parameter int MAX_LEN     = 16,
    parameter int SHOW_CYC    = 25000000,
    parameter int GAP_CYC     = 12500000,
    parameter int TIMEOUT_CYC = 150000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       rnd_en,
    input  logic [1:0] rnd_in,
    input  logic       btn_valid,
    input  logic [1:0] btn_sym,
    output logic       play_valid,
    output logic [1:0] play_sym,
    output logic [6:0] round,
    output logic       busy,
    output logic       win,
    output logic       lose
);

    localparam int AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int MAXA = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
    localparam int MAXC = (MAXA > TIMEOUT_CYC) ? MAXA : TIMEOUT_CYC;
    localparam int TW   = $clog2(MAXC + 1);

    localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYC - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYC - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [6:0]    LEN_MAX   = 7'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CAP,
        S_SHOW,
        S_GAP,
        S_WAIT,
        S_WIN,
        S_LOSE
    } state_t;

    state_t        state_q;
    logic          rnd_en_q;
    logic          play_valid_q;
    logic [1:0]    play_sym_q;
    logic [6:0]    round_q;
    logic [6:0]    idx_q;
    logic [TW-1:0] timer_q;
    logic          busy_q;
    logic          win_q;
    logic          lose_q;
    logic [1:0]    mem_q [0:MAX_LEN-1];

    logic [1:0] cap_sym_d;
    logic [6:0] idx_nxt_d;
    logic [1:0] exp_sym_d;
    logic [1:0] nxt_sym_d;
    logic       last_d;

    // The generator can emit 3, but the game only has symbols 0..2.
    assign cap_sym_d = (rnd_in == 2'd3) ? 2'd0 : rnd_in;
    assign idx_nxt_d = idx_q + 7'd1;
    assign exp_sym_d = mem_q[idx_q[AW-1:0]];
    assign nxt_sym_d = mem_q[idx_nxt_d[AW-1:0]];
    assign last_d    = (idx_q == round_q - 7'd1);

    always_ff @(posedge clk) begin
        if (state_q == S_CAP) begin
            mem_q[round_q[AW-1:0]] <= cap_sym_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rnd_en_q     <= 1'b0;
            play_valid_q <= 1'b0;
            play_sym_q   <= 2'd0;
            round_q      <= 7'd0;
            idx_q        <= 7'd0;
            timer_q      <= '0;
            busy_q       <= 1'b0;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
        end else begin
            rnd_en_q <= 1'b0;
            case (state_q)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (start) begin
                        state_q  <= S_REQ;
                        rnd_en_q <= 1'b1;
                        round_q  <= 7'd0;
                        idx_q    <= 7'd0;
                        timer_q  <= '0;
                        busy_q   <= 1'b1;
                        win_q    <= 1'b0;
                        lose_q   <= 1'b0;
                    end
                end
                S_REQ: begin
                    state_q <= S_CAP;
                end
                S_CAP: begin
                    // mem[0] is being written this edge in round one,
                    // so bypass the captured symbol straight to the display.
                    state_q      <= S_SHOW;
                    round_q      <= round_q + 7'd1;
                    idx_q        <= 7'd0;
                    timer_q      <= '0;
                    play_valid_q <= 1'b1;
                    play_sym_q   <= (round_q == 7'd0) ? cap_sym_d : mem_q[0];
                end
                S_SHOW: begin
                    if (timer_q == SHOW_LAST) begin
                        state_q      <= S_GAP;
                        timer_q      <= '0;
                        play_valid_q <= 1'b0;
                        play_sym_q   <= 2'd0;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_GAP: begin
                    if (timer_q == GAP_LAST) begin
                        timer_q <= '0;
                        if (idx_nxt_d == round_q) begin
                            state_q <= S_WAIT;
                            idx_q   <= 7'd0;
                        end else begin
                            state_q      <= S_SHOW;
                            idx_q        <= idx_nxt_d;
                            play_valid_q <= 1'b1;
                            play_sym_q   <= nxt_sym_d;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_WAIT: begin
                    // A press in the final timeout cycle takes priority.
                    if (btn_valid) begin
                        timer_q <= '0;
                        if (btn_sym != exp_sym_d) begin
                            state_q <= S_LOSE;
                            busy_q  <= 1'b0;
                            lose_q  <= 1'b1;
                        end else if (last_d) begin
                            if (round_q == LEN_MAX) begin
                                state_q <= S_WIN;
                                busy_q  <= 1'b0;
                                win_q   <= 1'b1;
                            end else begin
                                state_q  <= S_REQ;
                                rnd_en_q <= 1'b1;
                            end
                        end else begin
                            idx_q <= idx_nxt_d;
                        end
                    end else if (timer_q == TO_LAST) begin
                        state_q <= S_LOSE;
                        busy_q  <= 1'b0;
                        lose_q  <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rnd_en     = rnd_en_q;
    assign play_valid = play_valid_q;
    assign play_sym   = play_sym_q;
    assign round      = round_q;
    assign busy       = busy_q;
    assign win        = win_q;
    assign lose       = lose_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Directed bench for sequence_checker: a vector table for the main game
// flow plus hand-written multi-cycle corner sequences.
module tb_sequence_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       rnd_en;
    logic [1:0] rnd_in;
    logic       btn_valid;
    logic [1:0] btn_sym;
    logic       play_valid;
    logic [1:0] play_sym;
    logic [6:0] round;
    logic       busy;
    logic       win;
    logic       lose;

    int total = 0;
    int bad   = 0;

    sequence_checker #(
        .MAX_LEN    (3),
        .SHOW_CYC   (3),
        .GAP_CYC    (2),
        .TIMEOUT_CYC(10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rnd_en    (rnd_en),
        .rnd_in    (rnd_in),
        .btn_valid (btn_valid),
        .btn_sym   (btn_sym),
        .play_valid(play_valid),
        .play_sym  (play_sym),
        .round     (round),
        .busy      (busy),
        .win       (win),
        .lose      (lose)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic        st;
        logic [1:0]  ri;
        logic        bv;
        logic [1:0]  bs;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int n, logic st, logic [1:0] ri,
                                logic bv, logic [1:0] bs,
                                logic en, logic pv, logic [1:0] ps,
                                logic [6:0] rd, logic bz,
                                logic w, logic l);
        vec_t v;
        v.n   = n;
        v.st  = st;
        v.ri  = ri;
        v.bv  = bv;
        v.bs  = bs;
        v.exp = {en, pv, ps, rd, bz, w, l};
        return v;
    endfunction

    function automatic logic [13:0] outs();
        return {rnd_en, play_valid, play_sym, round, busy, win, lose};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_outs", 32'(outs()), 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic press(input logic [1:0] s);
        btn_valid = 1'b1;
        btn_sym   = s;
        tick();
        btn_valid = 1'b0;
    endtask

    // Entered in REQ; leaves the FSM in its first WAIT_IN cycle.
    task automatic next_round(input logic [1:0] s, input int k);
        rnd_in = s;
        tick();
        tick();
        repeat (5 * k) tick();
    endtask

    initial begin
        int en_cnt;
        reset     = 1'b1;
        start     = 1'b0;
        rnd_in    = 2'd0;
        btn_valid = 1'b0;
        btn_sym   = 2'd0;
        tick();
        do_reset();

        // outputs: en pv ps rd bz w l
        // first round with symbol 2, then timeout to LOSE
        tbl.push_back(mk(1,  1,2,0,0, 1,0,0,0,1,0,0));
        tbl.push_back(mk(1,  0,2,0,0, 0,0,0,0,1,0,0));
        tbl.push_back(mk(3,  0,2,0,0, 0,1,2,1,1,0,0));
        tbl.push_back(mk(2,  0,2,0,0, 0,0,0,1,1,0,0));
        tbl.push_back(mk(10, 0,2,0,0, 0,0,0,1,1,0,0));
        tbl.push_back(mk(1,  0,2,0,0, 0,0,0,1,0,0,1));
        // full win from LOSE: symbols 1,0,2
        tbl.push_back(mk(1,  1,1,0,0, 1,0,0,0,1,0,0));
        tbl.push_back(mk(1,  0,1,0,0, 0,0,0,0,1,0,0));
        tbl.push_back(mk(3,  0,1,0,0, 0,1,1,1,1,0,0));
        tbl.push_back(mk(2,  0,1,0,0, 0,0,0,1,1,0,0));
        tbl.push_back(mk(1,  0,1,0,0, 0,0,0,1,1,0,0));
        tbl.push_back(mk(1,  0,0,1,1, 1,0,0,1,1,0,0));
        tbl.push_back(mk(1,  0,0,0,0, 0,0,0,1,1,0,0));
        tbl.push_back(mk(3,  0,0,0,0, 0,1,1,2,1,0,0));
        tbl.push_back(mk(2,  0,0,0,0, 0,0,0,2,1,0,0));
        tbl.push_back(mk(3,  0,0,0,0, 0,1,0,2,1,0,0));
        tbl.push_back(mk(2,  0,0,0,0, 0,0,0,2,1,0,0));
        tbl.push_back(mk(1,  0,0,0,0, 0,0,0,2,1,0,0));
        tbl.push_back(mk(1,  0,0,1,1, 0,0,0,2,1,0,0));
        tbl.push_back(mk(1,  0,2,1,0, 1,0,0,2,1,0,0));
        tbl.push_back(mk(1,  0,2,0,0, 0,0,0,2,1,0,0));
        tbl.push_back(mk(3,  0,2,0,0, 0,1,1,3,1,0,0));
        tbl.push_back(mk(2,  0,2,0,0, 0,0,0,3,1,0,0));
        tbl.push_back(mk(3,  0,2,0,0, 0,1,0,3,1,0,0));
        tbl.push_back(mk(2,  0,2,0,0, 0,0,0,3,1,0,0));
        tbl.push_back(mk(3,  0,2,0,0, 0,1,2,3,1,0,0));
        tbl.push_back(mk(2,  0,2,0,0, 0,0,0,3,1,0,0));
        tbl.push_back(mk(1,  0,2,0,0, 0,0,0,3,1,0,0));
        tbl.push_back(mk(1,  0,2,1,1, 0,0,0,3,1,0,0));
        tbl.push_back(mk(1,  0,2,1,0, 0,0,0,3,1,0,0));
        tbl.push_back(mk(1,  0,2,1,2, 0,0,0,3,0,1,0));
        tbl.push_back(mk(2,  0,2,0,0, 0,0,0,3,0,1,0));

        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].n; c++) begin
                start     = tbl[i].st;
                rnd_in    = tbl[i].ri;
                btn_valid = tbl[i].bv;
                btn_sym   = tbl[i].bs;
                tick();
                start     = 1'b0;
                btn_valid = 1'b0;
                chk($sformatf("vec%0d.%0d", i, c),
                    32'(outs()), 32'(tbl[i].exp));
            end
        end

        // wrong press in round 2
        do_reset();
        pulse_start();
        next_round(2'd1, 1);
        press(2'd1);
        next_round(2'd0, 2);
        press(2'd1);
        chk("wrong_mid_lose", 32'(lose), 32'd0);
        press(2'd2);
        chk("wrong_lose", 32'(lose), 32'd1);
        chk("wrong_round", 32'(round), 32'd2);
        chk("wrong_busy", 32'(busy), 32'd0);
        en_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rnd_en) en_cnt++;
        end
        chk("wrong_no_req", 32'(en_cnt), 32'd0);
        chk("wrong_round_hold", 32'(round), 32'd2);

        // press in the last timeout cycle wins, timer restarts
        pulse_start();
        next_round(2'd1, 1);
        press(2'd1);
        next_round(2'd0, 2);
        repeat (9) tick();
        chk("to_edge_pre", 32'(lose), 32'd0);
        press(2'd1);
        chk("to_edge_press", 32'({lose, busy}), 32'b01);
        repeat (9) tick();
        chk("to_restart_9", 32'(lose), 32'd0);
        tick();
        chk("to_restart_10", 32'({lose, busy}), 32'b10);

        // inputs ignored during SHOW; rnd_in=3 stored as 0
        do_reset();
        pulse_start();
        rnd_in = 2'd3;
        tick();
        tick();
        chk("ign_show0", 32'({play_valid, play_sym}), 32'b100);
        start     = 1'b1;
        btn_valid = 1'b1;
        btn_sym   = 2'd1;
        tick();
        start     = 1'b0;
        btn_valid = 1'b0;
        chk("ign_show1", 32'(outs()), 32'({2'b01, 2'd0, 7'd1, 3'b100}));
        tick();
        chk("ign_show2", 32'({play_valid, play_sym}), 32'b100);
        tick();
        chk("ign_gap", 32'(play_valid), 32'd0);
        tick();
        tick();
        press(2'd0);
        chk("ign_next_req", 32'({rnd_en, round}), 32'({1'b1, 7'd1}));

        // reset in the middle of GAP, round 2
        do_reset();
        pulse_start();
        next_round(2'd1, 1);
        press(2'd1);
        rnd_in = 2'd0;
        tick();
        tick();
        repeat (3) tick();
        chk("mid_gap_state", 32'({play_valid, round}), 32'({1'b0, 7'd2}));
        do_reset();
        tick();
        chk("mid_idle", 32'(outs()), 32'd0);
        pulse_start();
        chk("mid_restart_req", 32'({rnd_en, round}), 32'({1'b1, 7'd0}));
        rnd_in = 2'd2;
        tick();
        tick();
        chk("mid_restart_show",
            32'({play_valid, play_sym, round}),
            32'({1'b1, 2'd2, 7'd1}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sequence_checker.md
Name: sequence_checker

Overview:
Consumer of the 2-bit game symbol stream from the LFSR symbol generator. Requests one new symbol per round, stores the growing sequence, and plays it back to the display/LED driver. It then checks player button entries against the stored sequence and declares win or lose. It sits between the symbol generator, the button debouncers and the display logic in the game top level.

Parameters:
MAX_LEN, 16, rounds needed to win (sequence memory depth, 2..64)
SHOW_CYC, 25000000, cycles each symbol is presented (play_valid high)
GAP_CYC, 12500000, blank cycles after each presented symbol
TIMEOUT_CYC, 150000000, max cycles allowed between player entries

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begin a new game
rnd_en  out  1  one-cycle enable to the symbol generator
rnd_in  in  2  generator symbol, valid one cycle after rnd_en
btn_valid  in  1  one-cycle pulse, player entered a symbol
btn_sym  in  2  player symbol, qualified by btn_valid
play_valid  out  1  high while a stored symbol is presented
play_sym  out  2  symbol being presented; 0 when play_valid low
round  out  7  current sequence length (0..MAX_LEN)
busy  out  1  high in every state except IDLE, WIN, LOSE
win  out  1  held high in WIN
lose  out  1  held high in LOSE

Behaviour:
- Reset (sync, active-high, overrides everything): state IDLE; rnd_en, play_valid, play_sym, round, busy, win, lose = 0. Index and timers are cleared. Memory contents are don't-care.
- States: IDLE, REQ, CAP, SHOW, GAP, WAIT_IN, WIN, LOSE.
- IDLE/WIN/LOSE + start: round := 0, clear win/lose, go to REQ. start is ignored in every other state.
- REQ: rnd_en = 1 for exactly this one cycle, then go to CAP.
- CAP: mem[round] := rnd_in (value 3 is stored as 0); round := round+1; idx := 0; go to SHOW.
- SHOW: play_valid = 1, play_sym = mem[idx] for exactly SHOW_CYC cycles, then go to GAP.
- GAP: play_valid = 0 for exactly GAP_CYC cycles, then idx := idx+1. If the new idx == round, go to WAIT_IN with idx := 0 and timer := 0; otherwise return to SHOW.
- WAIT_IN: timer increments every cycle and is cleared on each btn_valid.
  - btn_valid with btn_sym == mem[idx] and idx == round-1:
    - if round == MAX_LEN, go to WIN;
    - otherwise go to REQ (next round).
  - btn_valid with btn_sym == mem[idx] and idx < round-1: idx := idx+1.
  - btn_valid with btn_sym != mem[idx]: go to LOSE.
  - timer reaches TIMEOUT_CYC-1 with no btn_valid: go to LOSE. If btn_valid arrives in that same cycle, the button wins; the timeout is not taken.
- btn_valid outside WAIT_IN is ignored (no state change, not buffered).
- WIN/LOSE: win or lose held high, round holds its final value, and the FSM waits for start.
- Latency: start to rnd_en is 1 cycle. A CAP cycle to the first play_valid is 1 cycle.
- Timers are free of wrap: counter width is sized for the largest of SHOW_CYC, GAP_CYC and TIMEOUT_CYC.
- play_sym is registered; play_valid and play_sym change on the same edge.

Test Plan:
Setup for all cases: MAX_LEN=3, SHOW_CYC=3, GAP_CYC=2, TIMEOUT_CYC=10.
1. Reset, then start. Required: rnd_en high exactly one cycle, next cycle after start. With rnd_in=2 at CAP: round=1, play_valid high 3 cycles with play_sym=2, then low 2 cycles, then WAIT_IN.
2. Full win. Generator supplies 1,0,2. Player answers correctly each round (1 / 1,0 / 1,0,2). Required: three REQ pulses, playback lengths 1, 2, 3 symbols; win=1, round=3, busy=0 after the final correct press.
3. Wrong press. Round 2, sequence 1,0; press 1 then 2. Required: lose=1 the cycle after the second press; no further rnd_en; round stays 2.
4. Timeout. Enter WAIT_IN and give no btn_valid. Required: lose=1 after 10 cycles. Repeat with btn_valid (correct symbol) on cycle 9: no lose, timer restarts.
5. Ignored inputs. Pulse btn_valid and start during SHOW. Required: state, idx and round unchanged; playback completes normally. rnd_in=3 at CAP: stored and shown as play_sym=0.
6. Reset mid-GAP in round 2. Required: all outputs 0 the next cycle, state IDLE. A following start begins at round 1.
